hilo_seq_ctrl: RTL

- Sequences the shared multiply and divide units and arbitrates writes into the HI/LO register pair.
- Sits between the main control unit and the Mult, div, HI/LO mux and HI/LO register instances.
- Accepts mult/div requests, launches the selected unit, counts its fixed latency, and steers and strobes the HI/LO write.
- Raises a divide-by-zero exception request instead of writing, and stalls mfhi/mflo reads while an operation is in flight.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/hilo_pending_slot.sv | 36 +++
 rtl/hilo_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multiply/divide sequencer
// and its HI/LO write arbitration.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WRITE = 3'd2,
        EXC   = 3'd3,
        DONE  = 3'd4
    } hilo_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int CNT_W_DEF       = 6;

    typedef struct packed {
        logic sel;
        logic dz;
    } hilo_req_t;

endpackage

// File: rtl/hilo_pending_slot.sv
// One-entry holding buffer for a request accepted while
// the sequencer is busy.
module hilo_pending_slot
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_clear,
    input  hilo_req_t i_req,
    output logic      o_full,
    output hilo_req_t o_req
);

    logic      r_full;
    hilo_req_t r_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_req  <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_req  <= i_req;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_req  = r_req;

endmodule

// File: rtl/hilo_seq_ctrl.sv
// Launches mult/div, counts fixed latency, strobes the HI/LO
// write or raises a divide-by-zero exception.
module hilo_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic op_valid,
    input  logic op_sel,
    input  logic divisor_zero,
    input  logic abort,
    input  logic hilo_rd_req,
    output logic op_ready,
    output logic mult_start,
    output logic div_start,
    output logic div_or_mult,
    output logic hilo_w,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic stall
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    hilo_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cur_sel;
    logic             r_mult_start;
    logic             r_div_start;
    logic             r_hilo_w;
    logic             r_done;
    logic             r_exc;

    logic      w_full;
    logic      w_idle;
    logic      w_accept;
    logic      w_push;
    logic      w_pop;
    logic      w_launch;
    hilo_req_t w_new;
    hilo_req_t w_slot;
    hilo_req_t w_lreq;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = op_valid & ~w_full & ~abort;
    assign w_new    = '{sel: op_sel, dz: divisor_zero};

    // A held request always launches ahead of a new one.
    assign w_pop    = w_idle & w_full & ~abort;
    assign w_push   = w_accept & ~w_idle;
    assign w_launch = w_pop | (w_idle & w_accept);
    assign w_lreq   = w_full ? w_slot : w_new;

    hilo_pending_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (abort),
        .i_req   (w_new),
        .o_full  (w_full),
        .o_req   (w_slot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cur_sel    <= OP_MULT;
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_hilo_w     <= 1'b0;
            r_done       <= 1'b0;
            r_exc        <= 1'b0;
        end else begin
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_hilo_w     <= 1'b0;
            r_done       <= 1'b0;
            r_exc        <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_launch) begin
                            if (w_lreq.sel == OP_DIV && w_lreq.dz) begin
                                r_state <= EXC;
                                r_exc   <= 1'b1;
                            end else begin
                                r_state      <= RUN;
                                r_cur_sel    <= w_lreq.sel;
                                r_cnt        <= (w_lreq.sel == OP_DIV)
                                                ? DIV_LD : MULT_LD;
                                r_mult_start <= (w_lreq.sel == OP_MULT);
                                r_div_start  <= (w_lreq.sel == OP_DIV);
                            end
                        end
                    end
                    RUN: begin
                        if (r_cnt == '0) begin
                            r_state  <= WRITE;
                            r_hilo_w <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    WRITE: begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                    DONE:    r_state <= IDLE;
                    EXC:     r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Commit strobes are suppressed combinationally by abort.
    assign hilo_w       = r_hilo_w & ~abort;
    assign done         = r_done & ~abort;
    assign div_zero_exc = r_exc & ~abort;

    assign mult_start  = r_mult_start;
    assign div_start   = r_div_start;
    assign div_or_mult = ~r_cur_sel;
    assign op_ready    = ~w_full;
    assign busy        = ~w_idle | w_full;
    assign stall       = hilo_rd_req & busy;

endmodule
